// File: rtl/jpeg_color_pkg.sv
// ---------------------------------------------------------------------------
// jpeg_color_pkg : range modes, Q8 colour coefficients and offsets
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package jpeg_color_pkg;

  typedef enum logic [1:0] {
    MODE_FULL   = 2'b00,
    MODE_STUDIO = 2'b01,
    MODE_BYPASS = 2'b10
  } mode_e;

  localparam int COEF_W  = 10;
  localparam int C_UNITY = 256;

  // Rows are output lanes (Y, Cb, Cr); columns are R, G, B.
  localparam int FULL_COEF [3][3] = '{'{77, 150, 29}, '{-43, -85, 128}, '{128, -107, -21}};
  localparam int STUDIO_COEF [3][3] = '{'{66, 129, 25}, '{-38, -74, 112}, '{112, -94, -18}};

  localparam int OFF_Y_STUDIO = 16;
  localparam int OFF_C        = 128;

  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_STUDIO;
      2'b10:   return MODE_BYPASS;
      default: return MODE_FULL;
    endcase
  endfunction

  function automatic logic [COEF_W-1:0] coef_of(input mode_e m, input logic [1:0] lane,
                                                 input logic [1:0] comp);
    case (m)
      MODE_STUDIO: return COEF_W'(STUDIO_COEF[lane][comp]);
      MODE_BYPASS: return (lane == comp) ? COEF_W'(C_UNITY) : '0;
      default:     return COEF_W'(FULL_COEF[lane][comp]);
    endcase
  endfunction

  function automatic logic [2:0][COEF_W-1:0] lane_coefs(input mode_e m, input logic [1:0] lane);
    return {coef_of(m, lane, 2'd2), coef_of(m, lane, 2'd1), coef_of(m, lane, 2'd0)};
  endfunction

  // Offset in units of K = 2^(W-8).
  function automatic int lane_offset(input mode_e m, input logic [1:0] lane);
    if (m == MODE_BYPASS) return 0;
    if (lane != 2'd0)     return OFF_C;
    return (m == MODE_STUDIO) ? OFF_Y_STUDIO : 0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ycbcr_dot3.sv
// ---------------------------------------------------------------------------
// ycbcr_dot3 : 3-term signed dot product, registered products then sum
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ycbcr_dot3
  import jpeg_color_pkg::*;
#(
  parameter int W  = 8,
  parameter int SW = 19
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [2:0][W-1:0]             pix,
  input  logic [2:0][COEF_W-1:0]        coef,
  output logic signed [SW-1:0]          sum
);

  logic signed [SW-1:0] prod_q [3];
  logic signed [SW-1:0] prod_d [3];
  logic signed [SW-1:0] sum_q;
  logic signed [SW-1:0] sum_d;

  // Pixel is zero-extended, coefficient sign-extended, so the product is exact in SW bits.
  function automatic logic signed [SW-1:0] mul(input logic [W-1:0] p, input logic [COEF_W-1:0] c);
    return $signed({{(SW-W){1'b0}}, p}) * $signed({{(SW-COEF_W){c[COEF_W-1]}}, c});
  endfunction

  always_comb begin
    prod_d[0] = prod_q[0];
    prod_d[1] = prod_q[1];
    prod_d[2] = prod_q[2];
    sum_d     = sum_q;
    if (en) begin
      prod_d[0] = mul(pix[0], coef[0]);
      prod_d[1] = mul(pix[1], coef[1]);
      prod_d[2] = mul(pix[2], coef[2]);
      sum_d     = prod_q[0] + prod_q[1] + prod_q[2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q[0] <= '0;
      prod_q[1] <= '0;
      prod_q[2] <= '0;
      sum_q     <= '0;
    end else begin
      prod_q[0] <= prod_d[0];
      prod_q[1] <= prod_d[1];
      prod_q[2] <= prod_d[2];
      sum_q     <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

`default_nettype wire

// File: rtl/rgb_to_ycbcr_stream.sv
// ---------------------------------------------------------------------------
// rgb_to_ycbcr_stream : 3-stage streaming RGB->YCbCr with per-frame range mode
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rgb_to_ycbcr_stream #(
  parameter int W    = 8,
  parameter int FRAC = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   cfg_mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_r,
  input  logic [W-1:0] in_g,
  input  logic [W-1:0] in_b,
  input  logic         in_sof,
  input  logic         in_eol,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_y,
  output logic [W-1:0] out_cb,
  output logic [W-1:0] out_cr,
  output logic         out_sof,
  output logic         out_eol
);
  import jpeg_color_pkg::*;

  localparam int SW = W + FRAC + 3;
  localparam logic signed [SW-1:0] MAX_V = {{(SW-W){1'b0}}, {W{1'b1}}};

  logic              adv;
  logic              v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [2:0]        sof_q, sof_d, eol_q, eol_d;
  mode_e             mode_q, mode_d, mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;
  mode_e             pix_mode;
  logic [2:0][W-1:0] pix;
  logic [2:0][W-1:0] res;
  logic [2:0][W-1:0] out_q, out_d;

  assign pix = {in_b, in_g, in_r};

  // A sof pixel uses the freshly sampled mode; everything else inherits the frame's mode.
  always_comb begin
    adv       = !v3_q || out_ready;
    pix_mode  = in_sof ? decode_mode(cfg_mode) : mode_q;
    mode_d    = (in_valid && adv && in_sof) ? decode_mode(cfg_mode) : mode_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    v3_d      = v3_q;
    sof_d     = sof_q;
    eol_d     = eol_q;
    mode_s1_d = mode_s1_q;
    mode_s2_d = mode_s2_q;
    out_d     = out_q;
    if (adv) begin
      v1_d      = in_valid;
      v2_d      = v1_q;
      v3_d      = v2_q;
      sof_d     = {sof_q[1:0], in_sof && in_valid};
      eol_d     = {eol_q[1:0], in_eol && in_valid};
      mode_s1_d = pix_mode;
      mode_s2_d = mode_s1_q;
      out_d     = res;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic [2:0][COEF_W-1:0] coef;
    logic signed [SW-1:0]   sum;
    logic signed [SW-1:0]   val;
    logic [W-1:0]           lane_res;

    assign coef = lane_coefs(pix_mode, 2'(gi));

    ycbcr_dot3 #(.W(W), .SW(SW)) u_dot (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .pix   (pix),
      .coef  (coef),
      .sum   (sum)
    );

    always_comb begin
      val = (sum >>> FRAC) + (SW'(lane_offset(mode_s2_q, 2'(gi))) <<< (W - 8));
      if (val < 0)          lane_res = '0;
      else if (val > MAX_V) lane_res = '1;
      else                  lane_res = val[W-1:0];
    end

    assign res[gi] = lane_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      sof_q     <= '0;
      eol_q     <= '0;
      mode_q    <= MODE_FULL;
      mode_s1_q <= MODE_FULL;
      mode_s2_q <= MODE_FULL;
      out_q     <= '0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      sof_q     <= sof_d;
      eol_q     <= eol_d;
      mode_q    <= mode_d;
      mode_s1_q <= mode_s1_d;
      mode_s2_q <= mode_s2_d;
      out_q     <= out_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign out_sof   = sof_q[2];
  assign out_eol   = eol_q[2];
  assign out_y     = out_q[0];
  assign out_cb    = out_q[1];
  assign out_cr    = out_q[2];

endmodule

`default_nettype wire

// File: tb/tb_rgb_to_ycbcr_stream.sv
// ---------------------------------------------------------------------------
// tb_rgb_to_ycbcr_stream : directed bench with a frame-level colour model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rgb_to_ycbcr_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] cfg_mode;
  logic       in_valid, in_ready, in_sof, in_eol;
  logic [7:0] in_r, in_g, in_b;
  logic       out_valid, out_ready, out_sof, out_eol;
  logic [7:0] out_y, out_cb, out_cr;
  logic       bp_en;

  logic [1:0] cfg10;
  logic       v10, rdy10, sof10, eol10, ov10, osof10, oeol10;
  logic       ordy10;
  logic [9:0] r10, g10, b10, y10, cb10, cr10;

  rgb_to_ycbcr_stream #(.W(8), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_sof(in_sof), .in_eol(in_eol),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_cb(out_cb), .out_cr(out_cr),
    .out_sof(out_sof), .out_eol(out_eol)
  );

  rgb_to_ycbcr_stream #(.W(10), .FRAC(8)) dut10 (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg10),
    .in_valid(v10), .in_ready(rdy10),
    .in_r(r10), .in_g(g10), .in_b(b10), .in_sof(sof10), .in_eol(eol10),
    .out_valid(ov10), .out_ready(ordy10),
    .out_y(y10), .out_cb(cb10), .out_cr(cr10),
    .out_sof(osof10), .out_eol(oeol10)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Colour conversion straight from the published equations, plain integer arithmetic.
  function automatic int conv(input int m, input int lane, input int r, input int g,
                              input int b, input int w);
    int k;
    int v;
    k = 1 << (w - 8);
    case (m)
      1: begin
        if (lane == 0)      v = 16 * k + ((66 * r + 129 * g + 25 * b) >>> 8);
        else if (lane == 1) v = 128 * k + ((-38 * r - 74 * g + 112 * b) >>> 8);
        else                v = 128 * k + ((112 * r - 94 * g - 18 * b) >>> 8);
      end
      2: v = (lane == 0) ? r : (lane == 1) ? g : b;
      default: begin
        if (lane == 0)      v = (77 * r + 150 * g + 29 * b) >>> 8;
        else if (lane == 1) v = 128 * k + ((-43 * r - 85 * g + 128 * b) >>> 8);
        else                v = 128 * k + ((128 * r - 107 * g - 21 * b) >>> 8);
      end
    endcase
    if (v < 0) v = 0;
    if (v > (1 << w) - 1) v = (1 << w) - 1;
    return v;
  endfunction

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic       sof;
    logic       eol;
  } exp_t;

  exp_t sb[$];
  int   frame_mode = 0;

  // Scoreboard: every accepted pixel is modelled; every valid output cycle is compared to the head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      frame_mode = 0;
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (in_valid && in_ready) begin
        if (in_sof) frame_mode = (cfg_mode == 2'd3) ? 0 : int'(cfg_mode);
        e.y   = 8'(conv(frame_mode, 0, in_r, in_g, in_b, 8));
        e.cb  = 8'(conv(frame_mode, 1, in_r, in_g, in_b, 8));
        e.cr  = 8'(conv(frame_mode, 2, in_r, in_g, in_b, 8));
        e.sof = in_sof;
        e.eol = in_eol;
        sb.push_back(e);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", out_valid, 0);
        end else begin
          e = sb[0];
          chk("sb_y", out_y, e.y);
          chk("sb_cb", out_cb, e.cb);
          chk("sb_cr", out_cr, e.cr);
          chk("sb_sof", out_sof, e.sof);
          chk("sb_eol", out_eol, e.eol);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_px(input int r, input int g, input int b, input logic sof, input logic eol);
    bit ok;
    ok = 0;
    in_r = 8'(r); in_g = 8'(g); in_b = 8'(b);
    in_sof = sof; in_eol = eol; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
  endtask

  task automatic px_lit(input string nm, input logic [1:0] m, input int r, input int g, input int b,
                        input logic sof, input int ey, input int ecb, input int ecr);
    idle(4);
    cfg_mode = m;
    drive_px(r, g, b, sof, 1'b1);
    @(negedge clk); chk({nm, "_lat1"}, out_valid, 0);
    @(negedge clk); chk({nm, "_lat2"}, out_valid, 0);
    @(negedge clk); chk({nm, "_lat3"}, out_valid, 1);
    chk({nm, "_y"}, out_y, ey);
    chk({nm, "_cb"}, out_cb, ecb);
    chk({nm, "_cr"}, out_cr, ecr);
    chk({nm, "_sof"}, out_sof, sof);
    chk({nm, "_eol"}, out_eol, 1);
  endtask

  task automatic px10(input string nm, input logic [1:0] m, input int r, input int g, input int b,
                      input int ey, input int ecb, input int ecr);
    idle(4);
    cfg10 = m; r10 = 10'(r); g10 = 10'(g); b10 = 10'(b);
    sof10 = 1'b1; eol10 = 1'b1; v10 = 1'b1;
    @(negedge clk); chk({nm, "_rdy"}, rdy10, 1);
    @(posedge clk);
    #1;
    v10 = 1'b0; sof10 = 1'b0; eol10 = 1'b0;
    @(negedge clk); chk({nm, "_lat1"}, ov10, 0);
    @(negedge clk); chk({nm, "_lat2"}, ov10, 0);
    @(negedge clk); chk({nm, "_lat3"}, ov10, 1);
    chk({nm, "_y"}, y10, ey);
    chk({nm, "_cb"}, cb10, ecb);
    chk({nm, "_cr"}, cr10, ecr);
    chk({nm, "_sb"}, {osof10, oeol10}, 2'b11);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; bp_en = 1'b0; cfg_mode = 2'd0;
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; in_r = '0; in_g = '0; in_b = '0;
    cfg10 = 2'd0; v10 = 1'b0; sof10 = 1'b0; eol10 = 1'b0; r10 = '0; g10 = '0; b10 = '0;
    ordy10 = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", {out_y, out_cb, out_cr}, 0);
    chk("rst_out_sb", {out_sof, out_eol}, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(2);

    px_lit("full_white", 2'd0, 255, 255, 255, 1'b1, 255, 128, 128);
    px_lit("full_red", 2'd0, 255, 0, 0, 1'b0, 76, 85, 255);
    px_lit("full_blue", 2'd0, 0, 0, 255, 1'b0, 28, 255, 107);
    px_lit("studio_black", 2'd1, 0, 0, 0, 1'b1, 16, 128, 128);
    px_lit("studio_white", 2'd1, 255, 255, 255, 1'b0, 235, 128, 128);
    px_lit("mode3_red", 2'd3, 255, 0, 0, 1'b1, 76, 85, 255);

    // Frame A full with a mid-frame cfg change; frame B studio.
    idle(4);
    cfg_mode = 2'd0; drive_px(255, 255, 255, 1'b1, 1'b0);
    cfg_mode = 2'd1; drive_px(255, 0, 0, 1'b0, 1'b0);
    drive_px(0, 0, 255, 1'b0, 1'b1);
    drive_px(255, 255, 255, 1'b1, 1'b0);
    drive_px(255, 0, 0, 1'b0, 1'b0);
    drive_px(0, 0, 255, 1'b0, 1'b1);
    idle(6);
    chk("mode_switch_drain", sb.size(), 0);

    idle(4);
    bp_en = 1'b1;
    cfg_mode = 2'd0;
    for (int i = 0; i < 16; i++)
      drive_px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
               i == 0, (i % 4) == 3);
    bp_en = 1'b0;
    idle(30);
    chk("bp_drain", sb.size(), 0);

    idle(4);
    cfg_mode = 2'd0;
    drive_px(10, 20, 30, 1'b1, 1'b0);
    drive_px(40, 50, 60, 1'b0, 1'b0);
    drive_px(70, 80, 90, 1'b0, 1'b1);
    chk("rst_pre_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1 chk("rst_async_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_no_stale", out_valid, 0);
    end
    px_lit("post_rst_full", 2'd1, 255, 255, 255, 1'b0, 255, 128, 128);

    px10("byp10", 2'd2, 1023, 0, 512, 1023, 0, 512);
    px10("full10_white", 2'd0, 1023, 1023, 1023, 1023, 512, 512);
    px10("studio10_black", 2'd1, 0, 0, 0, 64, 512, 512);

    idle(5);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
